fila_busca: RTL and testbench
=============================

FILA_BUSCA -- requirements
Module: fila_busca

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
REQ-002 clock  in  1  single clock; all state sampled on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 endereco  in  64  current PC value from contador_programa.
REQ-005 pc_avanca  out  1  PC advance enable; high exactly in cycles where a memory request is accepted.
REQ-006 mem_req, mem_endereco  out  1, 64  instruction-memory request; mem_endereco = endereco, combinational.
REQ-007 mem_pronto  in  1  memory accepts a request when mem_req && mem_pronto at the clock edge.
REQ-008 mem_valido, mem_dado  in  1, 32  in-order response, one per accepted request, earliest 1 cycle after acceptance.
REQ-009 instr_valida, instrucao, instr_endereco  out  1, 32, 64  head entry offered to decode.
REQ-010 dec_pronto  in  1  decode consumes the head when instr_valida && dec_pronto.
REQ-011 desvio  in  1  flush: discard all buffered and in-flight instructions.

Function
REQ-012 Storage SHALL be a 4-entry circular queue; each entry holds an address, an instruction and a state VAZIO / PENDENTE / PRONTO.
REQ-013 On request acceptance the tail entry SHALL become PENDENTE with address = endereco, and the tail pointer SHALL advance mod 4.
REQ-014 mem_req SHALL be high iff reset_n=1, desvio=0, entry count < 4 and in-flight responses (kept + discarded) < 4.
REQ-015 Each kept mem_valido SHALL write mem_dado into the oldest PENDENTE entry and mark it PRONTO.
REQ-016 instr_valida SHALL be high iff the head entry is PRONTO; instrucao and instr_endereco SHALL come from the head entry.
REQ-017 A consumed head SHALL become VAZIO and the head pointer SHALL advance mod 4 at the same edge.
REQ-018 Minimum latency: request accepted at edge N, response at edge N+1, instr_valida high after edge N+1 (2 cycles from request to decode).
REQ-019 Acceptance, response and consumption SHALL all be allowed in the same cycle; with a full queue, consumption SHALL NOT enable a same-cycle request (no bypass).
REQ-020 On desvio=1: all entries SHALL become VAZIO, pointers SHALL reset to 0, and the PENDENTE count SHALL be added to a 3-bit discard counter. No request and no consumption occur in that cycle.
REQ-021 While the discard counter > 0, each mem_valido SHALL decrement it and its data SHALL be dropped. A mem_valido in the same cycle as desvio SHALL also be dropped.
REQ-022 Requests SHALL resume in the cycle after desvio; responses to them SHALL be kept only after the discard counter reaches 0.
REQ-023 mem_valido arriving with no PENDENTE entry and discard counter = 0 is a protocol error; it SHALL be ignored.

Reset
REQ-024 reset_n=0 SHALL immediately clear all entries to VAZIO, pointers and counters to 0, and force mem_req=0, pc_avanca=0 and instr_valida=0.
REQ-025 Reset mid-operation SHALL drop all in-flight requests without issuing discard credit; the memory is reset by the same reset_n.
REQ-026 On the first edge after reset_n rises, mem_req SHALL be high.

Configuration
REQ-027 Macro FILA_BUSCA_CONTADORES_EN: when defined, adds output cont_bolhas (32 bits), which counts cycles with dec_pronto=1 and instr_valida=0.
REQ-028 cont_bolhas SHALL saturate at 0xFFFFFFFF, SHALL be cleared only by reset, and SHALL NOT be cleared by desvio.
REQ-029 When the macro is undefined, the cont_bolhas port and its logic SHALL be absent and the block's behaviour SHALL otherwise be identical.

Verification
REQ-030 Streaming: endereco 0,1,2..., mem_pronto=1, 1-cycle memory, dec_pronto=1 -> after 2-cycle fill, one instruction per cycle with instr_endereco 0,1,2 in order.
REQ-031 Backpressure: dec_pronto=0 -> exactly 4 requests accepted, then mem_req=0 and pc_avanca=0; one consumption re-enables mem_req on the next cycle.
REQ-032 Flush: 3 PENDENTE entries, desvio pulse -> instr_valida=0 next cycle, the next 3 mem_valido are dropped, and the 4th response appears with the new address.
REQ-033 Simultaneous events: a cycle with desvio=1 and mem_valido=1 -> that response is dropped and no request is issued.
REQ-034 Reset mid-stream: reset_n low with 2 PRONTO and 2 PENDENTE entries -> all outputs are 0 immediately, and mem_req=1 on the first edge after release.
REQ-035 With FILA_BUSCA_CONTADORES_EN: 5 starved cycles -> cont_bolhas=5; the count persists across desvio; preloading the counter to 0xFFFFFFFF and adding one more starved cycle -> it remains 0xFFFFFFFF.

Source files
------------

// File: rtl/fila_busca.sv
// fila_busca: 4-entry instruction fetch queue between the PC, instruction memory and decode.
// Optional FILA_BUSCA_CONTADORES_EN adds cont_bolhas, a saturating count of decode-starved cycles.
module fila_busca (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] endereco,
  output logic        pc_avanca,
  output logic        mem_req,
  output logic [63:0] mem_endereco,
  input  logic        mem_pronto,
  input  logic        mem_valido,
  input  logic [31:0] mem_dado,
  output logic        instr_valida,
  output logic [31:0] instrucao,
  output logic [63:0] instr_endereco,
  input  logic        dec_pronto,
  input  logic        desvio
`ifdef FILA_BUSCA_CONTADORES_EN
  ,
  output logic [31:0] cont_bolhas
`endif
);
  typedef enum logic [1:0] {VAZIO, PENDENTE, PRONTO} estado_t;
  estado_t     st    [4];
  logic [63:0] ends  [4];
  logic [31:0] dados [4];
  logic [1:0]  cab, cauda, alvo;
  logic [2:0]  cnt, pend, desc;
  logic        consome, guarda, descarta;
  // Handshakes; responses fill in order, so the oldest PENDENTE sits right after the PRONTO run.
  always_comb begin
    mem_endereco   = endereco;
    mem_req        = reset_n && !desvio && !cnt[2] && ({1'b0, pend} + {1'b0, desc} < 4'd4);
    pc_avanca      = mem_req && mem_pronto;
    instr_valida   = st[cab] == PRONTO;
    instrucao      = dados[cab];
    instr_endereco = ends[cab];
    consome        = instr_valida && dec_pronto && !desvio;
    guarda         = mem_valido && !desvio && desc == 3'd0 && pend != 3'd0;
    descarta       = mem_valido && !desvio && desc != 3'd0;
    alvo           = cab + 2'(cnt - pend);
  end
  // Entry states, pointers and counters; a flush turns pending entries into discard credit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) st[i] <= VAZIO;
      cab   <= 2'd0;
      cauda <= 2'd0;
      cnt   <= 3'd0;
      pend  <= 3'd0;
      desc  <= 3'd0;
    end else if (desvio) begin
      for (int i = 0; i < 4; i++) st[i] <= VAZIO;
      cab   <= 2'd0;
      cauda <= 2'd0;
      cnt   <= 3'd0;
      pend  <= 3'd0;
      desc  <= desc + pend - 3'(mem_valido && (pend != 3'd0 || desc != 3'd0));
    end else begin
      if (pc_avanca) begin
        st[cauda] <= PENDENTE;
        cauda     <= cauda + 2'd1;
      end
      if (guarda) st[alvo] <= PRONTO;
      if (consome) begin
        st[cab] <= VAZIO;
        cab     <= cab + 2'd1;
      end
      cnt  <= cnt + 3'(pc_avanca) - 3'(consome);
      pend <= pend + 3'(pc_avanca) - 3'(guarda);
      if (descarta) desc <= desc - 3'd1;
    end
  end
  // Entry payloads need no reset; their state tag decides whether they are meaningful.
  always_ff @(posedge clock) begin
    if (pc_avanca) ends[cauda] <= endereco;
    if (guarda) dados[alvo] <= mem_dado;
  end
`ifdef FILA_BUSCA_CONTADORES_EN
  // Saturating bubble counter: decode ready but nothing to offer; only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cont_bolhas <= 32'd0;
    else if (dec_pronto && !instr_valida && cont_bolhas != 32'hFFFF_FFFF) cont_bolhas <= cont_bolhas + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fila_busca.sv
// tb_fila_busca: table vectors, directed corner sequences and a randomized queue-model check for fila_busca.
module tb_fila_busca;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic [63:0] endereco = '0, mem_endereco, instr_endereco;
  logic        pc_avanca, mem_req, mem_pronto = 1'b0, mem_valido = 1'b0;
  logic [31:0] mem_dado = '0, instrucao;
  logic        instr_valida, dec_pronto = 1'b0, desvio = 1'b0;
`ifdef FILA_BUSCA_CONTADORES_EN
  logic [31:0] cont_bolhas;
`endif
  int errors = 0, checks = 0;

  fila_busca dut (
    .clock(clock), .reset_n(reset_n), .endereco(endereco), .pc_avanca(pc_avanca),
    .mem_req(mem_req), .mem_endereco(mem_endereco), .mem_pronto(mem_pronto),
    .mem_valido(mem_valido), .mem_dado(mem_dado), .instr_valida(instr_valida),
    .instrucao(instrucao), .instr_endereco(instr_endereco), .dec_pronto(dec_pronto),
    .desvio(desvio)
`ifdef FILA_BUSCA_CONTADORES_EN
    , .cont_bolhas(cont_bolhas)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic dsv, mp, dp, mv; logic [31:0] md; logic [63:0] e;
    logic req, pca, iv; logic [63:0] ie; logic [31:0] ins;
  } vec_t;
  typedef struct { logic [63:0] a; logic [31:0] d; bit p; } ent_t;

  vec_t        tab [16];
  ent_t        q [$];
  logic [63:0] mem_q [$];
  int          dref;

  function automatic logic [31:0] h(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  task automatic set_in(input logic d, input logic mp, input logic dp, input logic mv,
                        input logic [31:0] md, input logic [63:0] e);
    desvio = d; mem_pronto = mp; dec_pronto = dp; mem_valido = mv; mem_dado = md; endereco = e;
  endtask

  task automatic nxt;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    set_in(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    nxt();
    reset_n = 1'b1;
  endtask

  initial begin
    tab[0]  = '{0,1,1,0,0,64'h100,              1,1,0,64'h0,0};
    tab[1]  = '{0,1,1,1,h(64'h100),64'h104,     1,1,0,64'h0,0};
    tab[2]  = '{0,1,1,1,h(64'h104),64'h108,     1,1,1,64'h100,h(64'h100)};
    tab[3]  = '{0,1,1,1,h(64'h108),64'h10C,     1,1,1,64'h104,h(64'h104)};
    tab[4]  = '{0,1,0,1,h(64'h10C),64'h110,     1,1,1,64'h108,h(64'h108)};
    tab[5]  = '{0,1,0,1,h(64'h110),64'h114,     1,1,1,64'h108,h(64'h108)};
    tab[6]  = '{0,1,0,1,h(64'h114),64'h118,     0,0,1,64'h108,h(64'h108)};
    tab[7]  = '{0,1,1,0,0,64'h118,              0,0,1,64'h108,h(64'h108)};
    tab[8]  = '{0,1,0,0,0,64'h118,              1,1,1,64'h10C,h(64'h10C)};
    tab[9]  = '{1,1,1,0,0,64'h200,              0,0,1,64'h10C,h(64'h10C)};
    tab[10] = '{0,1,1,0,0,64'h200,              1,1,0,64'h0,0};
    tab[11] = '{0,1,1,1,h(64'h118),64'h204,     1,1,0,64'h0,0};
    tab[12] = '{0,1,1,1,h(64'h200),64'h208,     1,1,0,64'h0,0};
    tab[13] = '{0,0,1,0,0,64'h20C,              1,0,1,64'h200,h(64'h200)};
    tab[14] = '{0,0,1,1,h(64'h204),64'h20C,     1,0,0,64'h0,0};
    tab[15] = '{0,0,0,1,h(64'h208),64'h20C,     1,0,1,64'h204,h(64'h204)};

    nxt();
    @(negedge clock);
    chk("reset_req", mem_req, 0);
    chk("reset_pca", pc_avanca, 0);
    chk("reset_iv", instr_valida, 0);
    nxt();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_in(tab[i].dsv, tab[i].mp, tab[i].dp, tab[i].mv, tab[i].md, tab[i].e);
      @(negedge clock);
      chk($sformatf("tab%0d_req", i), mem_req, tab[i].req);
      chk($sformatf("tab%0d_pca", i), pc_avanca, tab[i].pca);
      chk($sformatf("tab%0d_iv", i), instr_valida, tab[i].iv);
      chk($sformatf("tab%0d_maddr", i), mem_endereco, tab[i].e);
      if (tab[i].iv) begin
        chk($sformatf("tab%0d_ie", i), instr_endereco, tab[i].ie);
        chk($sformatf("tab%0d_ins", i), instrucao, tab[i].ins);
      end
      nxt();
    end

    // Flush with three pending requests: three drops, the fourth response is kept.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 0, 0, 0, 64'h1000 + 64'(k * 4));
      @(negedge clock);
      chk("flush_fill_req", mem_req, 1);
      nxt();
    end
    set_in(1, 1, 1, 0, 0, 64'h300);
    @(negedge clock);
    chk("flush_req_low", mem_req, 0);
    chk("flush_pca_low", pc_avanca, 0);
    nxt();
    for (int k = 0; k < 4; k++) begin
      set_in(0, k == 0, 1, 1, (k == 3) ? 32'hCAFE_0300 : 32'h1111 * (k + 1), 64'h300);
      @(negedge clock);
      chk("flush_iv_low", instr_valida, 0);
      if (k == 0) chk("flush_resume_pca", pc_avanca, 1);
      nxt();
    end
    set_in(0, 0, 0, 0, 0, 64'h0);
    @(negedge clock);
    chk("flush_iv", instr_valida, 1);
    chk("flush_ie", instr_endereco, 64'h300);
    chk("flush_ins", instrucao, 32'hCAFE_0300);

    // Flush coinciding with a response: that response is consumed as a drop.
    do_reset();
    set_in(0, 1, 0, 0, 0, 64'h500);
    nxt();
    set_in(1, 1, 0, 1, 32'h0BAD, 64'h504);
    @(negedge clock);
    chk("sim_req", mem_req, 0);
    chk("sim_pca", pc_avanca, 0);
    nxt();
    set_in(0, 1, 0, 0, 0, 64'h400);
    @(negedge clock);
    chk("sim_req_resume", mem_req, 1);
    nxt();
    set_in(0, 0, 0, 1, 32'h0400_BEEF, 64'h0);
    @(negedge clock);
    chk("sim_iv_low", instr_valida, 0);
    nxt();
    set_in(0, 0, 0, 0, 0, 64'h0);
    @(negedge clock);
    chk("sim_iv", instr_valida, 1);
    chk("sim_ie", instr_endereco, 64'h400);
    chk("sim_ins", instrucao, 32'h0400_BEEF);

    // Reset with two PRONTO and two PENDENTE entries.
    do_reset();
    set_in(0, 1, 0, 0, 0, 64'h600);
    nxt();
    set_in(0, 1, 0, 1, h(64'h600), 64'h604);
    nxt();
    set_in(0, 1, 0, 1, h(64'h604), 64'h608);
    nxt();
    set_in(0, 1, 0, 0, 0, 64'h60C);
    @(negedge clock);
    chk("rst_pre_iv", instr_valida, 1);
    nxt();
    set_in(0, 1, 1, 0, 0, 64'h610);
    @(negedge clock);
    chk("rst_full_req", mem_req, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_pca", pc_avanca, 0);
    chk("rst_iv", instr_valida, 0);
    nxt();
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("rst_release_req", mem_req, 1);
    nxt();
    chk("rst_after_iv", instr_valida, 0);
    chk("rst_after_req", mem_req, 1);

    // Randomized traffic against a queue-level model with an in-order memory.
    do_reset();
    q.delete();
    mem_q.delete();
    dref = 0;
    for (int c = 0; c < 3000; c++) begin
      int  npend;
      bit  e_req, e_pca, e_iv;
      desvio     = $urandom_range(0, 19) == 0;
      mem_pronto = $urandom_range(0, 3) != 0;
      dec_pronto = $urandom_range(0, 2) != 0;
      endereco   = {$urandom, $urandom};
      mem_valido = mem_q.size() > 0 && $urandom_range(0, 4) < 3;
      mem_dado   = mem_valido ? h(mem_q[0]) : $urandom;
      @(negedge clock);
      npend = 0;
      foreach (q[i]) if (!q[i].p) npend++;
      e_req = !desvio && q.size() < 4 && npend + dref < 4;
      e_pca = e_req && mem_pronto;
      e_iv  = q.size() > 0 && q[0].p;
      chk("rnd_req", mem_req, e_req);
      chk("rnd_pca", pc_avanca, e_pca);
      chk("rnd_iv", instr_valida, e_iv);
      if (e_iv) begin
        chk("rnd_ie", instr_endereco, q[0].a);
        chk("rnd_ins", instrucao, q[0].d);
      end
      if (mem_valido) void'(mem_q.pop_front());
      if (desvio) begin
        dref = dref + npend - ((mem_valido && npend + dref > 0) ? 1 : 0);
        q.delete();
      end else begin
        if (mem_valido) begin
          if (dref > 0) dref--;
          else begin
            for (int i = 0; i < q.size(); i++)
              if (!q[i].p) begin
                q[i].d = mem_dado;
                q[i].p = 1;
                break;
              end
          end
        end
        if (e_iv && dec_pronto) void'(q.pop_front());
        if (e_pca) begin
          q.push_back('{endereco, 32'h0, 1'b0});
          mem_q.push_back(endereco);
        end
      end
      nxt();
    end

`ifdef FILA_BUSCA_CONTADORES_EN
    // Bubble counter: counts starved cycles, survives flushes, saturates.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(0, 0, 1, 0, 0, 64'h0);
      nxt();
    end
    chk("bolhas_5", cont_bolhas, 32'd5);
    set_in(1, 0, 0, 0, 0, 64'h0);
    nxt();
    set_in(0, 0, 0, 0, 0, 64'h0);
    nxt();
    chk("bolhas_desvio", cont_bolhas, 32'd5);
    force dut.cont_bolhas = 32'hFFFF_FFFF;
    #1 release dut.cont_bolhas;
    set_in(0, 0, 1, 0, 0, 64'h0);
    nxt();
    chk("bolhas_sat", cont_bolhas, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
